gshare_index: RTL and testbench
===============================

# gshare_index

Parametrised gshare index generator with speculative global history and checkpointed misprediction recovery. It sits in fetch between the PC register and the pattern history table. Each cycle it forms the PHT index from the speculative history and PC bits. It shifts predicted outcomes into the history as branches are fetched, saves a history checkpoint per in-flight branch, and restores the correct history in one cycle when a branch resolves as mispredicted.

## Interface
- G_WIDTH, 16: global history length in bits; must be ≥ 2.
- I_WIDTH, 10: PHT index width; must be ≤ G_WIDTH.
- CK_DEPTH, 8: number of checkpoints (in-flight conditional branches); must be a power of 2, ≥ 2. TAG_W = $clog2(CK_DEPTH) is derived.
- clk  in  1  clock; all state updates on the rising edge.
- resetN  in  1  asynchronous, active-low reset.
- pc  in  32  fetch PC; bits [I_WIDTH+1:2] are used.
- index  out  I_WIDTH  PHT index, combinational.
- brValid  in  1  a conditional branch is predicted this cycle.
- predTaken  in  1  predicted direction of that branch.
- brReady  out  1  a checkpoint is free; the branch is accepted when brValid && brReady.
- brTag  out  TAG_W  checkpoint tag given to the branch accepted this cycle; this equals tail.
- resolveValid  in  1  a branch resolves this cycle.
- resolveTag  in  TAG_W  tag of the resolving branch.
- mispredict  in  1  the resolving branch was mispredicted.
- actualTaken  in  1  resolved direction.
- retireValid  in  1  free the oldest checkpoint (head).
- ghr  out  G_WIDTH  current speculative history.
- count  out  TAG_W+1  number of occupied checkpoints.

## Operation
- State: ghr; ckpt[CK_DEPTH] of G_WIDTH bits each; head and tail pointers (TAG_W bits each, wrapping modulo CK_DEPTH); count.
- Index:
  - index = H ^ pc[I_WIDTH+1:2].
  - H is the folded history (see Configuration).
- Accept (brValid && brReady):
  - ckpt[tail] <= ghr. This stores the history before the branch.
  - ghr <= {ghr[G_WIDTH-2:0], predTaken}.
  - tail <= tail+1; count <= count+1.
- brReady:
  - brReady = (count != CK_DEPTH) && !(resolveValid && mispredict).
  - During a recovery cycle, any accept is dropped.
- Correct resolve (resolveValid && !mispredict): no state change.
- Mispredict (resolveValid && mispredict, tag t):
  - ghr <= {ckpt[t][G_WIDTH-2:0], actualTaken}.
  - tail <= t+1, which squashes all younger checkpoints.
  - count <= ((t-head) mod CK_DEPTH)+1.
- Retire (retireValid && count != 0):
  - head <= head+1; count <= count-1.
  - retireValid when count == 0 is ignored.
- Simultaneous events:
  - Accept and retire in the same cycle: count is unchanged; both pointers advance.
  - Mispredict and retire in the same cycle: head advances, and count <= (t-head) mod CK_DEPTH, computed with the old head. The retired entry must be older than t.
  - Mispredict takes priority over accept.
- Illegal inputs (the bench must not drive them; behaviour is unspecified):
  - resolveTag naming a free slot.
  - Retiring the mispredicting tag in the same cycle.

## Timing
- Reset (resetN low): ghr=0, head=0, tail=0, count=0, all ckpt=0, so brReady=1, brTag=0, and index=pc[I_WIDTH+1:2]. Reset takes effect immediately, including mid-operation and during recovery.
- index is combinational, from the current ghr and pc, in the same cycle.
- ghr, count and brTag reflect an accept, retire or mispredict on the cycle after the edge.
- Recovery latency is 1 cycle: the cycle after a mispredict, index already uses the repaired history.
- Back-to-back accepts are supported every cycle until full.

## Configuration
- GHR_FOLD_EN defined:
  - H is the XOR of ghr split into I_WIDTH-bit chunks, starting from bit 0.
  - The last chunk is zero-extended.
- GHR_FOLD_EN undefined:
  - H = ghr[I_WIDTH-1:0].
  - Upper history bits affect only checkpoints and recovery, not the index.

## Test plan
All scenarios use the defaults G_WIDTH=16, I_WIDTH=10, CK_DEPTH=8.
- Reset with pc=0x00000FFC -> ghr=0, count=0, brReady=1, index=0x3FF.
- Accept T,N,T on consecutive cycles -> brTag=0,1,2; then ghr=0x0005, count=3.
- From the state above, mispredict tag 1 with actualTaken=1 -> next cycle ghr=0x0003, count=2, brTag=2.
- Accept 8 branches with no retire -> brReady=0 at count=8; a held brValid leaves ghr unchanged. Pulse retireValid -> count=7 and brReady=1 the next cycle.
- At count=3, accept and retire in the same cycle -> count stays 3, and head and tail both advance by 1.
- ghr=0xFC00, pc=0 -> index=0x03F with GHR_FOLD_EN, 0x000 without it. Asserting resetN low mid-sequence clears all state without waiting for a clock edge.

Source files
------------

// File: rtl/gshare_index_if.sv
`default_nettype none
// ============================================================================
//  Module      : gshare_index_if
//  Description : Fetch-side bundle between the PC/branch predictor logic and
//                the gshare index generator (index, branch accept,
//                resolve/recovery, retire and status).
//  Revision    : 1.0 - initial release
// ============================================================================
interface gshare_index_if #(
    parameter int G_WIDTH  = 16,
    parameter int I_WIDTH  = 10,
    parameter int CK_DEPTH = 8
);
    localparam int TAG_W = $clog2(CK_DEPTH);

    logic [31:0]        pc;
    logic [I_WIDTH-1:0] index;
    logic               brValid;
    logic               predTaken;
    logic               brReady;
    logic [TAG_W-1:0]   brTag;
    logic               resolveValid;
    logic [TAG_W-1:0]   resolveTag;
    logic               mispredict;
    logic               actualTaken;
    logic               retireValid;
    logic [G_WIDTH-1:0] ghr;
    logic [TAG_W:0]     count;

    // Fetch / resolve logic side
    modport master (
        output pc, brValid, predTaken, resolveValid, resolveTag,
               mispredict, actualTaken, retireValid,
        input  index, brReady, brTag, ghr, count
    );

    // Index generator side
    modport slave (
        input  pc, brValid, predTaken, resolveValid, resolveTag,
               mispredict, actualTaken, retireValid,
        output index, brReady, brTag, ghr, count
    );
endinterface
`default_nettype wire

// File: rtl/gshare_index.sv
`default_nettype none
// ============================================================================
//  Module      : gshare_index
//  Description : gshare PHT index generator with speculative global history,
//                one history checkpoint per in-flight branch and single-cycle
//                misprediction recovery.
//                Optional macro GHR_FOLD_EN: fold the whole history into the
//                index by XOR of I_WIDTH-bit chunks (otherwise only the low
//                I_WIDTH history bits are hashed).
//  Revision    : 1.0 - initial release
// ============================================================================
module gshare_index #(
    parameter int G_WIDTH  = 16,
    parameter int I_WIDTH  = 10,
    parameter int CK_DEPTH = 8
) (
    input  wire logic      clk,
    input  wire logic      resetN,
    gshare_index_if.slave  bus
);
    localparam int             TAG_W    = $clog2(CK_DEPTH);
    localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
    localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
    localparam logic [TAG_W:0]   CNT_FULL = (TAG_W+1)'(CK_DEPTH);

    logic [G_WIDTH-1:0] ghr_q, ghr_d;
    logic [G_WIDTH-1:0] ckpt_q [CK_DEPTH];
    logic [TAG_W-1:0]   head_q, head_d;
    logic [TAG_W-1:0]   tail_q, tail_d;
    logic [TAG_W:0]     count_q, count_d;

    logic               w_mispredict;
    logic               w_ready;
    logic               w_accept;
    logic               w_retire;
    logic [TAG_W-1:0]   w_dist;
    logic [I_WIDTH-1:0] w_hist;
    logic               w_unused_pc;

    assign w_mispredict = bus.resolveValid && bus.mispredict;
    assign w_ready      = (count_q != CNT_FULL) && !w_mispredict;
    assign w_accept     = bus.brValid && w_ready;
    assign w_retire     = bus.retireValid && (count_q != '0);
    // Age of the mispredicting branch relative to the oldest live checkpoint
    assign w_dist       = bus.resolveTag - head_q;
    assign w_unused_pc  = ^{bus.pc[31:I_WIDTH+2], bus.pc[1:0]};

`ifdef GHR_FOLD_EN
    // Fold the full history: XOR of I_WIDTH-bit chunks, last chunk zero-extended
    always_comb begin
        w_hist = '0;
        for (int c = 0; c * I_WIDTH < G_WIDTH; c++) begin
            for (int b = 0; b < I_WIDTH; b++) begin
                if (c * I_WIDTH + b < G_WIDTH) begin
                    w_hist[b] = w_hist[b] ^ ghr_q[c * I_WIDTH + b];
                end
            end
        end
    end
`else
    // Only the youngest I_WIDTH outcomes participate in the hash
    always_comb begin
        w_hist = ghr_q[I_WIDTH-1:0];
    end
`endif

    assign bus.index   = w_hist ^ bus.pc[I_WIDTH+1:2];
    assign bus.brReady = w_ready;
    assign bus.brTag   = tail_q;
    assign bus.ghr     = ghr_q;
    assign bus.count   = count_q;

    // Next-state: recovery overrides any accept; retire is independent
    always_comb begin
        ghr_d   = ghr_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (w_mispredict) begin
            ghr_d   = {ckpt_q[bus.resolveTag][G_WIDTH-2:0], bus.actualTaken};
            tail_d  = bus.resolveTag + TAG_ONE;
            count_d = w_retire ? {1'b0, w_dist} : ({1'b0, w_dist} + CNT_ONE);
        end else if (w_accept) begin
            ghr_d   = {ghr_q[G_WIDTH-2:0], bus.predTaken};
            tail_d  = tail_q + TAG_ONE;
            count_d = w_retire ? count_q : (count_q + CNT_ONE);
        end else if (w_retire) begin
            count_d = count_q - CNT_ONE;
        end
        if (w_retire) begin
            head_d = head_q + TAG_ONE;
        end
    end

    // State registers and checkpoint capture (history before the branch)
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ghr_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < CK_DEPTH; i++) begin
                ckpt_q[i] <= '0;
            end
        end else begin
            ghr_q   <= ghr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (w_accept) begin
                ckpt_q[tail_q] <= ghr_q;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_gshare_index.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gshare_index
//  Description : Self-checking bench for gshare_index with a queue-based
//                reference model of the in-flight branch checkpoints.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gshare_index;
    logic clk;
    logic resetN;
    int   n_cmp;
    int   n_fail;

    gshare_index_if #(.G_WIDTH(16), .I_WIDTH(10), .CK_DEPTH(8)) bus ();

    gshare_index #(.G_WIDTH(16), .I_WIDTH(10), .CK_DEPTH(8)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: ordered list of live branches, oldest first
    typedef struct {
        logic [2:0]  tag;
        logic [15:0] hist;
    } ck_t;
    ck_t         mq[$];
    logic [15:0] m_ghr;
    int          m_head;

    function automatic logic [9:0] m_fold(input logic [15:0] g);
`ifdef GHR_FOLD_EN
        int v;
        int h;
        v = int'(g);
        h = 0;
        while (v != 0) begin
            h = h ^ (v & 'h3FF);
            v = v >> 10;
        end
        return h[9:0];
`else
        return g[9:0];
`endif
    endfunction

    function automatic logic [2:0] m_tail();
        return 3'((m_head + mq.size()) % 8);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ghr  = '0;
        m_head = 0;
    endtask

    task automatic idle();
        bus.brValid      = 1'b0;
        bus.predTaken    = 1'b0;
        bus.resolveValid = 1'b0;
        bus.resolveTag   = '0;
        bus.mispredict   = 1'b0;
        bus.actualTaken  = 1'b0;
        bus.retireValid  = 1'b0;
    endtask

    // One clock; model follows the branch/retire rules from the current inputs
    task automatic tick();
        bit mp;
        bit acc;
        bit ret;
        int k;
        mp  = bus.resolveValid && bus.mispredict;
        acc = bus.brValid && (mq.size() != 8) && !mp;
        ret = bus.retireValid && (mq.size() != 0);
        @(posedge clk);
        if (mp) begin
            k = -1;
            foreach (mq[i]) if (mq[i].tag == bus.resolveTag) k = i;
            if (k >= 0) begin
                m_ghr = {mq[k].hist[14:0], bus.actualTaken};
                while (mq.size() > k + 1) void'(mq.pop_back());
            end
        end else if (acc) begin
            mq.push_back('{tag: m_tail(), hist: m_ghr});
            m_ghr = {m_ghr[14:0], bus.predTaken};
        end
        if (ret) begin
            void'(mq.pop_front());
            m_head = (m_head + 1) % 8;
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        resetN = 1'b0;
        @(posedge clk);
        #1;
        resetN = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        idle();
        bus.pc = 32'h0000_0FFC;
        resetN = 1'b0;
        #1;
        n_cmp++; if (bus.ghr !== 16'h0000) begin n_fail++; $display("FAIL reset_ghr got %h exp 0000", bus.ghr); end
        n_cmp++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        n_cmp++; if (bus.brReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", bus.brReady); end
        n_cmp++; if (bus.index !== 10'h3FF) begin n_fail++; $display("FAIL reset_index got %h exp 3ff", bus.index); end
        n_cmp++; if (bus.brTag !== 3'd0) begin n_fail++; $display("FAIL reset_tag got %0d exp 0", bus.brTag); end
        @(posedge clk);
        #1;
        resetN = 1'b1;
        model_reset();
    endtask

    task automatic test_accept();
        logic [2:0] pat;
        pat = 3'b101;
        for (int i = 0; i < 3; i++) begin
            bus.brValid   = 1'b1;
            bus.predTaken = pat[2-i];
            n_cmp++; if (bus.brTag !== 3'(i)) begin n_fail++; $display("FAIL accept_tag got %0d exp %0d", bus.brTag, i); end
            tick();
        end
        idle();
        n_cmp++; if (bus.ghr !== 16'h0005) begin n_fail++; $display("FAIL accept_ghr got %h exp 0005", bus.ghr); end
        n_cmp++; if (bus.count !== 4'd3) begin n_fail++; $display("FAIL accept_count got %0d exp 3", bus.count); end
    endtask

    task automatic test_mispredict();
        bus.resolveValid = 1'b1;
        bus.resolveTag   = 3'd1;
        bus.mispredict   = 1'b1;
        bus.actualTaken  = 1'b1;
        bus.brValid      = 1'b1;
        bus.predTaken    = 1'b1;
        #1;
        n_cmp++; if (bus.brReady !== 1'b0) begin n_fail++; $display("FAIL recov_ready got %b exp 0", bus.brReady); end
        tick();
        idle();
        n_cmp++; if (bus.ghr !== 16'h0003) begin n_fail++; $display("FAIL recov_ghr got %h exp 0003", bus.ghr); end
        n_cmp++; if (bus.count !== 4'd2) begin n_fail++; $display("FAIL recov_count got %0d exp 2", bus.count); end
        n_cmp++; if (bus.brTag !== 3'd2) begin n_fail++; $display("FAIL recov_tag got %0d exp 2", bus.brTag); end
        n_cmp++; if (bus.index !== (m_fold(16'h0003) ^ bus.pc[11:2])) begin n_fail++; $display("FAIL recov_index got %h", bus.index); end
    endtask

    task automatic test_full();
        logic [15:0] held;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.brValid   = 1'b1;
            bus.predTaken = 1'($urandom);
            tick();
        end
        idle();
        #1;
        n_cmp++; if (bus.brReady !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b exp 0", bus.brReady); end
        n_cmp++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL full_count got %0d exp 8", bus.count); end
        held = m_ghr;
        bus.brValid   = 1'b1;
        bus.predTaken = ~held[0];
        tick();
        n_cmp++; if (bus.ghr !== held) begin n_fail++; $display("FAIL full_hold got %h exp %h", bus.ghr, held); end
        bus.brValid     = 1'b0;
        bus.retireValid = 1'b1;
        tick();
        idle();
        #1;
        n_cmp++; if (bus.count !== 4'd7) begin n_fail++; $display("FAIL retire_count got %0d exp 7", bus.count); end
        n_cmp++; if (bus.brReady !== 1'b1) begin n_fail++; $display("FAIL retire_ready got %b exp 1", bus.brReady); end
    endtask

    task automatic test_accept_retire();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.brValid   = 1'b1;
            bus.predTaken = 1'($urandom);
            tick();
        end
        bus.brValid     = 1'b1;
        bus.retireValid = 1'b1;
        n_cmp++; if (bus.brTag !== 3'd3) begin n_fail++; $display("FAIL ar_tag_pre got %0d exp 3", bus.brTag); end
        tick();
        idle();
        n_cmp++; if (bus.count !== 4'd3) begin n_fail++; $display("FAIL ar_count got %0d exp 3", bus.count); end
        n_cmp++; if (bus.brTag !== 3'd4) begin n_fail++; $display("FAIL ar_tag got %0d exp 4", bus.brTag); end
        // Head is now 1: mispredicting tag 1 leaves exactly one live branch
        bus.resolveValid = 1'b1;
        bus.resolveTag   = 3'd1;
        bus.mispredict   = 1'b1;
        bus.actualTaken  = 1'b0;
        tick();
        idle();
        n_cmp++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL ar_head got count %0d exp 1", bus.count); end
        n_cmp++; if (bus.ghr !== m_ghr) begin n_fail++; $display("FAIL ar_ghr got %h exp %h", bus.ghr, m_ghr); end
    endtask

    task automatic test_fold();
        logic [9:0] exp_idx;
        do_reset();
        bus.pc = 32'h0;
        for (int i = 0; i < 16; i++) begin
            bus.brValid     = 1'b1;
            bus.predTaken   = (i < 6);
            bus.retireValid = 1'b1;
            tick();
        end
        idle();
`ifdef GHR_FOLD_EN
        exp_idx = 10'h03F;
`else
        exp_idx = 10'h000;
`endif
        n_cmp++; if (bus.ghr !== 16'hFC00) begin n_fail++; $display("FAIL fold_ghr got %h exp fc00", bus.ghr); end
        n_cmp++; if (bus.index !== exp_idx) begin n_fail++; $display("FAIL fold_index got %h exp %h", bus.index, exp_idx); end
    endtask

    task automatic test_random();
        int k;
        bit mp;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            idle();
            bus.pc        = $urandom;
            bus.brValid   = ($urandom_range(0, 3) != 0);
            bus.predTaken = 1'($urandom);
            bus.retireValid = ($urandom_range(0, 3) == 0);
            k  = 0;
            mp = 1'b0;
            if (mq.size() != 0 && $urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, mq.size() - 1);
                bus.resolveValid = 1'b1;
                bus.resolveTag   = mq[k].tag;
                bus.mispredict   = 1'($urandom);
                bus.actualTaken  = 1'($urandom);
                mp = bus.mispredict;
            end
            if (mp && k == 0) bus.retireValid = 1'b0;
            #1;
            n_cmp++; if (bus.index !== (m_fold(m_ghr) ^ bus.pc[11:2])) begin n_fail++; $display("FAIL rnd_index cyc %0d got %h exp %h", cyc, bus.index, m_fold(m_ghr) ^ bus.pc[11:2]); end
            n_cmp++; if (bus.ghr !== m_ghr) begin n_fail++; $display("FAIL rnd_ghr cyc %0d got %h exp %h", cyc, bus.ghr, m_ghr); end
            n_cmp++; if (bus.count !== 4'(mq.size())) begin n_fail++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", cyc, bus.count, mq.size()); end
            n_cmp++; if (bus.brTag !== m_tail()) begin n_fail++; $display("FAIL rnd_tag cyc %0d got %0d exp %0d", cyc, bus.brTag, m_tail()); end
            n_cmp++; if (bus.brReady !== ((mq.size() != 8) && !mp)) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, bus.brReady, (mq.size() != 8) && !mp); end
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.brValid   = 1'b1;
            bus.predTaken = 1'b1;
            tick();
        end
        // Start a recovery and pull reset between clock edges
        bus.brValid      = 1'b0;
        bus.resolveValid = 1'b1;
        bus.resolveTag   = 3'd2;
        bus.mispredict   = 1'b1;
        bus.actualTaken  = 1'b1;
        #2;
        resetN = 1'b0;
        #1;
        n_cmp++; if (bus.ghr !== 16'h0000) begin n_fail++; $display("FAIL areset_ghr got %h exp 0000", bus.ghr); end
        n_cmp++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL areset_count got %0d exp 0", bus.count); end
        n_cmp++; if (bus.brTag !== 3'd0) begin n_fail++; $display("FAIL areset_tag got %0d exp 0", bus.brTag); end
        idle();
        @(posedge clk);
        #1;
        resetN = 1'b1;
        model_reset();
        n_cmp++; if (bus.brReady !== 1'b1) begin n_fail++; $display("FAIL areset_ready got %b exp 1", bus.brReady); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        resetN = 1'b0;
        bus.pc = '0;
        idle();
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_accept();
        test_mispredict();
        test_full();
        test_accept_retire();
        test_fold();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
